// File: rtl/axis_fp_mult_sched_if.sv
// Bundle of the operand streams, the multiplier operand/result bus, the result stream and status.
// The slave modport is the scheduler's view; the master modport is the surrounding datapath's view.
interface axis_fp_mult_sched_if #(
  parameter int DATA     = 32,
  parameter int MULT_LAT = 4
);
  localparam int IW = $clog2(MULT_LAT + 1);

  logic            s_axis_valid_a;
  logic            s_axis_ready_a;
  logic [DATA-1:0] s_axis_data_a;
  logic            s_axis_valid_b;
  logic            s_axis_ready_b;
  logic [DATA-1:0] s_axis_data_b;
  logic [DATA-1:0] mult_op_a;
  logic [DATA-1:0] mult_op_b;
  logic [DATA-1:0] mult_result;
  logic            m_axis_valid;
  logic            m_axis_ready;
  logic [DATA-1:0] m_axis_data;
  logic [IW-1:0]   inflight;
  logic            ovf_err;

  modport slave (
    input  s_axis_valid_a, s_axis_data_a, s_axis_valid_b, s_axis_data_b,
    input  mult_result, m_axis_ready,
    output s_axis_ready_a, s_axis_ready_b, mult_op_a, mult_op_b,
    output m_axis_valid, m_axis_data, inflight, ovf_err
  );

  modport master (
    output s_axis_valid_a, s_axis_data_a, s_axis_valid_b, s_axis_data_b,
    output mult_result, m_axis_ready,
    input  s_axis_ready_a, s_axis_ready_b, mult_op_a, mult_op_b,
    input  m_axis_valid, m_axis_data, inflight, ovf_err
  );
endinterface

// File: rtl/axis_fp_mult_sched.sv
// Joins operand streams A/B into multiplier issues, tracks in-flight ops in a valid shift
// register and buffers products in a credit-protected fall-through FIFO.
module axis_fp_mult_sched #(
  parameter int DATA       = 32,
  parameter int MULT_LAT   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input logic               axis_clk,
  input logic               rst,
  axis_fp_mult_sched_if.slave bus
);
  localparam int IW = $clog2(MULT_LAT + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;

  logic [MULT_LAT-1:0] vld_q, vld_d;
  logic [IW-1:0]       inflight_q, inflight_d;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [DATA-1:0]     op_a_q, op_b_q;
  logic                ovf_q;
  logic [DATA-1:0]     mem [FIFO_DEPTH];

  logic [SW-1:0] occupancy;
  logic          credit_ok, fire, capture, pop, full, wr_en, m_valid;

  // A pop in the current cycle is deliberately ignored; its slot is reusable next cycle.
  assign occupancy = SW'(count_q) + SW'(inflight_q);
  assign credit_ok = occupancy < SW'(FIFO_DEPTH);
  assign fire      = !rst && bus.s_axis_valid_a && bus.s_axis_valid_b && credit_ok;
  assign capture   = vld_q[MULT_LAT-1];
  assign m_valid   = !rst && (count_q != '0);
  assign pop       = m_valid && bus.m_axis_ready;
  assign full      = count_q == CW'(FIFO_DEPTH);
  assign wr_en     = capture && (!full || pop);

  always_comb begin
    vld_d      = MULT_LAT'({vld_q, fire});
    inflight_d = inflight_q;
    count_d    = count_q;
    case ({fire, capture})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (rst) begin
      vld_q      <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (fire) begin
        op_a_q <= bus.s_axis_data_a;
        op_b_q <= bus.s_axis_data_b;
      end
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
      if (capture && full && !pop) ovf_q <= 1'b1;
    end
  end

  // Storage has no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge axis_clk) begin
    if (wr_en) mem[wr_ptr_q] <= bus.mult_result;
  end

  assign bus.s_axis_ready_a = !rst && bus.s_axis_valid_b && credit_ok;
  assign bus.s_axis_ready_b = !rst && bus.s_axis_valid_a && credit_ok;
  assign bus.mult_op_a      = op_a_q;
  assign bus.mult_op_b      = op_b_q;
  assign bus.m_axis_valid   = m_valid;
  assign bus.m_axis_data    = mem[rd_ptr_q];
  assign bus.inflight       = inflight_q;
  assign bus.ovf_err        = ovf_q;
endmodule

// File: tb/tb_axis_fp_mult_sched.sv
// Bench for axis_fp_mult_sched: directed operand vectors with hand-computed products,
// scoreboard queue filled at issue and drained by an independent output monitor.
module tb_axis_fp_mult_sched;
  localparam int DATA       = 32;
  localparam int MULT_LAT   = 4;
  localparam int FIFO_DEPTH = 8;

  logic axis_clk = 1'b0;
  logic rst      = 1'b1;
  always #5 axis_clk = ~axis_clk;

  axis_fp_mult_sched_if #(.DATA(DATA), .MULT_LAT(MULT_LAT)) bus ();

  axis_fp_mult_sched #(.DATA(DATA), .MULT_LAT(MULT_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .axis_clk(axis_clk),
    .rst     (rst),
    .bus     (bus)
  );

  // Hand-computed single-precision products: a * b = p.
  logic [31:0] vec_a [16] = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40000000, 32'h40400000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40400000, 32'h40800000, 32'h40400000,
                              32'h40800000, 32'hBF800000, 32'h3FC00000, 32'h3F000000};
  logic [31:0] vec_b [16] = '{32'h40400000, 32'h40A00000, 32'h40000000, 32'h40400000,
                              32'h40A00000, 32'h40800000, 32'h40E00000, 32'h40A00000,
                              32'h40800000, 32'h40C00000, 32'h40A00000, 32'h40E00000,
                              32'h40C00000, 32'h40000000, 32'h40200000, 32'h3FC00000};
  logic [31:0] vec_p [16] = '{32'h40C00000, 32'h40A00000, 32'h40800000, 32'h41100000,
                              32'h41200000, 32'h41400000, 32'h41600000, 32'h41700000,
                              32'h41800000, 32'h41900000, 32'h41A00000, 32'h41A80000,
                              32'h41C00000, 32'hC0000000, 32'h40700000, 32'h3F400000};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [9:0]  e;
    logic [47:0] p;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) return {s, e[7:0] + 8'd1, p[46:24]};
    return {s, e[7:0], p[45:23]};
  endfunction

  // Multiplier model: the operand register is the first of MULT_LAT stages, so the
  // product is ready just before the capture edge.
  logic [31:0] mp [MULT_LAT-1];
  always @(posedge axis_clk) begin
    mp[0] <= fp_mul(bus.mult_op_a, bus.mult_op_b);
    for (int i = 1; i < MULT_LAT - 1; i++) mp[i] <= mp[i-1];
  end
  assign bus.mult_result = mp[MULT_LAT-2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge axis_clk) begin
    if (!rst && bus.m_axis_valid === 1'b1 && bus.m_axis_ready === 1'b1) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_unexpected: got 0x%0h, expected no output", bus.m_axis_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        $display("out  #%0d data=0x%08h expected=0x%08h", n_out, bus.m_axis_data, e);
        check("out_data", 64'(bus.m_axis_data), 64'(e));
      end
    end
  end

  task automatic offer(input logic va, input logic vb, input int idx,
                       output logic fired, output logic ra, output logic rb);
    bus.s_axis_valid_a = va;
    bus.s_axis_valid_b = vb;
    bus.s_axis_data_a  = va ? vec_a[idx % 16] : 32'h0;
    bus.s_axis_data_b  = vb ? vec_b[idx % 16] : 32'h0;
    @(negedge axis_clk);
    ra    = bus.s_axis_ready_a;
    rb    = bus.s_axis_ready_b;
    fired = va & vb & ra & rb;
    if (fired) begin
      exp_q.push_back(vec_p[idx % 16]);
      $display("issue a=0x%08h b=0x%08h expect=0x%08h", vec_a[idx % 16], vec_b[idx % 16],
               vec_p[idx % 16]);
    end
    @(posedge axis_clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.s_axis_valid_a = 1'b0;
    bus.s_axis_valid_b = 1'b0;
    repeat (n) begin
      @(posedge axis_clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic f, ra, rb;
    int   nxt, nf, budget, out0;

    bus.s_axis_valid_a = 1'b1;
    bus.s_axis_valid_b = 1'b1;
    bus.s_axis_data_a  = '0;
    bus.s_axis_data_b  = '0;
    bus.m_axis_ready   = 1'b1;

    // Reset state
    @(negedge axis_clk);
    check("rst_ready_a", 64'(bus.s_axis_ready_a), 64'(0));
    check("rst_ready_b", 64'(bus.s_axis_ready_b), 64'(0));
    @(posedge axis_clk);
    #1;
    rst = 1'b0;
    bus.s_axis_valid_a = 1'b0;
    bus.s_axis_valid_b = 1'b0;
    check("rst_m_valid", 64'(bus.m_axis_valid), 64'(0));
    check("rst_inflight", 64'(bus.inflight), 64'(0));
    check("rst_op_a", 64'(bus.mult_op_a), 64'(0));
    check("rst_ovf", 64'(bus.ovf_err), 64'(0));

    // 1: single op, latency MULT_LAT+1
    offer(1'b1, 1'b1, 0, f, ra, rb);
    bus.s_axis_valid_a = 1'b0;
    bus.s_axis_valid_b = 1'b0;
    check("t1_fire", 64'(f), 64'(1));
    check("t1_op_a", 64'(bus.mult_op_a), 64'h40000000);
    check("t1_op_b", 64'(bus.mult_op_b), 64'h40400000);
    check("t1_inflight", 64'(bus.inflight), 64'(1));
    for (int k = 1; k < MULT_LAT; k++) begin
      @(posedge axis_clk);
      #1;
      check("t1_early_valid", 64'(bus.m_axis_valid), 64'(0));
    end
    @(posedge axis_clk);
    #1;
    check("t1_valid", 64'(bus.m_axis_valid), 64'(1));
    check("t1_data", 64'(bus.m_axis_data), 64'h40C00000);
    check("t1_op_hold", 64'(bus.mult_op_a), 64'h40000000);
    @(posedge axis_clk);
    #1;
    check("t1_popped", 64'(bus.m_axis_valid), 64'(0));

    // 2: backpressure, credit limit and conservative pop credit
    bus.m_axis_ready = 1'b0;
    nxt = 16;
    nf  = 0;
    for (int c = 0; c < 14; c++) begin
      offer(1'b1, 1'b1, nxt, f, ra, rb);
      if (f) begin nxt++; nf++; end
    end
    check("t2_fired", 64'(nf), 64'(FIFO_DEPTH));
    check("t2_ready_low", 64'(bus.s_axis_ready_a), 64'(0));
    check("t2_inflight", 64'(bus.inflight), 64'(0));
    check("t2_m_valid", 64'(bus.m_axis_valid), 64'(1));
    bus.m_axis_ready = 1'b1;
    offer(1'b1, 1'b1, nxt, f, ra, rb);
    check("t2_no_same_edge_fire", 64'(f), 64'(0));
    bus.m_axis_ready = 1'b0;
    offer(1'b1, 1'b1, nxt, f, ra, rb);
    check("t2_next_edge_fire", 64'(f), 64'(1));
    if (f) begin nxt++; nf++; end
    bus.m_axis_ready = 1'b1;
    budget = 40;
    while (nf < 12 && budget > 0) begin
      offer(1'b1, 1'b1, nxt, f, ra, rb);
      if (f) begin nxt++; nf++; end
      budget--;
    end
    check("t2_all_fired", 64'(nf), 64'(12));
    idle(12);
    check("t2_ovf", 64'(bus.ovf_err), 64'(0));
    check("t2_drained", 64'(exp_q.size()), 64'(0));

    // 3: join, lone A waits
    for (int c = 0; c < 3; c++) begin
      offer(1'b1, 1'b0, nxt, f, ra, rb);
      check("t3_lone_no_fire", 64'(f), 64'(0));
      check("t3_lone_ready_a", 64'(ra), 64'(0));
    end
    out0 = n_out;
    offer(1'b1, 1'b1, nxt, f, ra, rb);
    nxt++;
    check("t3_ready_a", 64'(ra), 64'(1));
    check("t3_ready_b", 64'(rb), 64'(1));
    check("t3_fire", 64'(f), 64'(1));
    idle(8);
    check("t3_one_result", 64'(n_out - out0), 64'(1));

    // 4: prefill five results, then stream 20 ops across pointer wrap
    bus.m_axis_ready = 1'b0;
    nf = 0;
    budget = 20;
    while (nf < 5 && budget > 0) begin
      offer(1'b1, 1'b1, nxt, f, ra, rb);
      if (f) begin nxt++; nf++; end
      budget--;
    end
    idle(MULT_LAT + 2);
    check("t4_prefill_inflight", 64'(bus.inflight), 64'(0));
    bus.m_axis_ready = 1'b1;
    nf = 0;
    budget = 40;
    while (nf < 20 && budget > 0) begin
      check("t4_valid_held", 64'(bus.m_axis_valid), 64'(1));
      offer(1'b1, 1'b1, nxt, f, ra, rb);
      if (f) begin nxt++; nf++; end
      budget--;
    end
    check("t4_fired", 64'(nf), 64'(20));
    idle(12);
    check("t4_drained", 64'(exp_q.size()), 64'(0));

    // 5: reset mid-flight
    bus.m_axis_ready = 1'b0;
    nf = 0;
    for (int c = 0; c < 5; c++) begin
      offer(1'b1, 1'b1, nxt, f, ra, rb);
      if (f) begin nxt++; nf++; end
    end
    check("t5_fired", 64'(nf), 64'(5));
    idle(1);
    check("t5_inflight_pre", 64'(bus.inflight), 64'(3));
    check("t5_valid_pre", 64'(bus.m_axis_valid), 64'(1));
    rst = 1'b1;
    @(posedge axis_clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("t5_valid_post", 64'(bus.m_axis_valid), 64'(0));
    check("t5_inflight_post", 64'(bus.inflight), 64'(0));
    check("t5_op_a_post", 64'(bus.mult_op_a), 64'(0));
    bus.m_axis_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge axis_clk);
      #1;
      check("t5_no_output", 64'(bus.m_axis_valid), 64'(0));
    end

    // 6: sustained streaming
    out0 = n_out;
    nf = 0;
    for (int c = 0; c < 64; c++) begin
      offer(1'b1, 1'b1, nxt, f, ra, rb);
      if (f) begin nxt++; nf++; end
    end
    check("t6_fired", 64'(nf), 64'(64));
    idle(MULT_LAT);
    @(negedge axis_clk);
    #1;
    check("t6_results", 64'(n_out - out0), 64'(64));
    check("t6_drained", 64'(exp_q.size()), 64'(0));
    check("final_ovf", 64'(bus.ovf_err), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
